// File: rtl/task_dispatcher.sv
// task_dispatcher: hands single tasks from an upstream buffer to one of
// NUM_PE processing engines in round-robin order. An engine is picked when it
// is neither occupied by a dispatched task nor reporting busy. A task is then
// requested from upstream, registered, and announced with a one-cycle start
// pulse on the chosen engine.
// Optional build macro: DISPATCH_STATS_EN adds a 32-bit dispatch_count output
// that counts start pulses.
module task_dispatcher #(
    parameter int TASK_SIZE = 144,
    parameter int NUM_PE    = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 task_valid,
    input  logic [TASK_SIZE-1:0] task_data,
    output logic                 task_ready,
    output logic [NUM_PE-1:0]    pe_start,
    output logic [TASK_SIZE-1:0] pe_data,
    input  logic [NUM_PE-1:0]    pe_busy,
    input  logic [NUM_PE-1:0]    pe_done,
`ifdef DISPATCH_STATS_EN
    output logic [31:0]          dispatch_count,
`endif
    output logic                 all_idle
);

    localparam int PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam logic [PTR_W-1:0] LAST_PE = PTR_W'(NUM_PE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [NUM_PE-1:0]  occ;
    logic [NUM_PE-1:0]  occ_next;
    logic [NUM_PE-1:0]  free_vec;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   sel;
    logic [PTR_W-1:0]   pick;
    logic               found;

    // Adds an offset to a pointer, wrapping at NUM_PE (which need not be a power of two).
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_PE) begin
            sum = sum - NUM_PE;
        end
        return sum[PTR_W-1:0];
    endfunction

    assign free_vec   = ~occ & ~pe_busy;
    assign task_ready = (state == S_REQ);
    assign all_idle   = (state == S_IDLE) && (occ == '0) && (pe_busy == '0);

    // Round-robin search: first free engine at or after rr_ptr, using the registered occupancy.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            if (!found && free_vec[wrap_add(rr_ptr, k)]) begin
                found = 1'b1;
                pick  = wrap_add(rr_ptr, k);
            end
        end
    end

    // Occupancy update: completions release engines first, then a dispatch claims its engine.
    always_comb begin
        occ_next = occ & ~pe_done;
        if (state == S_ISSUE) begin
            occ_next[sel] = 1'b1;
        end
    end

    // Start pulse is decoded from the issue state so it lasts exactly one cycle.
    always_comb begin
        pe_start = '0;
        if (state == S_ISSUE) begin
            pe_start[sel] = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: pick an engine, wait for a task, then issue it.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (found) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (task_valid) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath registers: occupancy, selected engine, payload and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            occ     <= '0;
            sel     <= '0;
            rr_ptr  <= '0;
            pe_data <= '0;
        end else begin
            occ <= occ_next;
            if (state == S_IDLE && found) begin
                sel <= pick;
            end
            if (state == S_REQ && task_valid) begin
                pe_data <= task_data;
            end
            if (state == S_ISSUE) begin
                rr_ptr <= (sel == LAST_PE) ? '0 : sel + 1'b1;
            end
        end
    end

`ifdef DISPATCH_STATS_EN
    logic [31:0] dispatch_cnt;

    // Free-running dispatch counter, one step per start pulse, wrapping naturally.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dispatch_cnt <= '0;
        end else if (state == S_ISSUE) begin
            dispatch_cnt <= dispatch_cnt + 32'd1;
        end
    end

    assign dispatch_count = dispatch_cnt;
`endif

endmodule

// File: tb/tb_task_dispatcher.sv
// tb_task_dispatcher: scoreboard bench for task_dispatcher with NUM_PE=4.
// Each driven task pushes its expected engine, payload and start cycle; a
// monitor on the falling edge pops and compares whenever pe_start fires.
module tb_task_dispatcher;

    localparam int TASK_SIZE = 144;
    localparam int NUM_PE    = 4;

    logic                 clk;
    logic                 rstn;
    logic                 task_valid;
    logic [TASK_SIZE-1:0] task_data;
    logic                 task_ready;
    logic [NUM_PE-1:0]    pe_start;
    logic [TASK_SIZE-1:0] pe_data;
    logic [NUM_PE-1:0]    pe_busy;
    logic [NUM_PE-1:0]    pe_done;
    logic                 all_idle;
`ifdef DISPATCH_STATS_EN
    logic [31:0]          dispatch_count;
`endif

    typedef struct {
        int                   eng;
        logic [TASK_SIZE-1:0] data;
        int                   cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   num_checks;
    int   num_fails;

    task_dispatcher #(
        .TASK_SIZE(TASK_SIZE),
        .NUM_PE(NUM_PE)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .task_valid(task_valid),
        .task_data(task_data),
        .task_ready(task_ready),
        .pe_start(pe_start),
        .pe_data(pe_data),
        .pe_busy(pe_busy),
        .pe_done(pe_done),
`ifdef DISPATCH_STATS_EN
        .dispatch_count(dispatch_count),
`endif
        .all_idle(all_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to check start-pulse latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [159:0] actual, input logic [159:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [TASK_SIZE-1:0] mkData(input logic [7:0] lsb);
        return {$urandom(), $urandom(), $urandom(), $urandom(), 8'h5C, lsb};
    endfunction

    // Waits (bounded) for task_ready, pulses task_valid for one cycle and records the expectation.
    task automatic applyStimulus(input logic [TASK_SIZE-1:0] data, input int eng);
        int waited;
        waited = 0;
        while (!task_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!task_ready) begin
            checkOutput("ready_timeout", 160'(task_ready), 160'(1));
            return;
        end
        task_data  = data;
        task_valid = 1'b1;
        sb.push_back('{eng, data, cyc + 1});
        @(negedge clk);
        task_valid = 1'b0;
    endtask

    task automatic pulseDone(input logic [NUM_PE-1:0] mask);
        pe_done = mask;
        @(negedge clk);
        pe_done = '0;
    endtask

    // Scoreboard monitor: every start pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (pe_start != '0) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_start", 160'(pe_start), 160'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("pe_start", 160'(pe_start), 160'(1) << e.eng);
                checkOutput("pe_data", 160'(pe_data), 160'(e.data));
                checkOutput("start_latency", 160'(cyc), 160'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [TASK_SIZE-1:0] d;
        logic                 seen_ready;
        cyc        = 0;
        num_checks = 0;
        num_fails  = 0;
        rstn       = 1'b0;
        task_valid = 1'b0;
        task_data  = '0;
        pe_busy    = '0;
        pe_done    = '0;

        repeat (3) @(negedge clk);
        checkOutput("rst_task_ready", 160'(task_ready), 160'(0));
        checkOutput("rst_pe_start", 160'(pe_start), 160'(0));
        checkOutput("rst_pe_data", 160'(pe_data), 160'(0));
        checkOutput("rst_all_idle", 160'(all_idle), 160'(1));

        // Release: one edge later the dispatcher should be requesting a task.
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_rst", 160'(task_ready), 160'(1));

        // Fill all four engines in round-robin order.
        applyStimulus(mkData(8'hA5), 0);
        applyStimulus(mkData(8'h11), 1);
        applyStimulus(mkData(8'h22), 2);
        d = mkData(8'h33);
        applyStimulus(d, 3);

        seen_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (task_ready) seen_ready = 1'b1;
        end
        checkOutput("ready_when_full", 160'(seen_ready), 160'(0));
        checkOutput("all_idle_busy", 160'(all_idle), 160'(0));
        checkOutput("pe_data_hold", 160'(pe_data), 160'(d));

        // Free engine 2 only: it must be the next target and the pointer moves past it.
        pulseDone(4'b0100);
        applyStimulus(mkData(8'h44), 2);
        @(negedge clk);
        checkOutput("rr_ptr_after_2", 160'(dut.rr_ptr), 160'(3));

        // Free engines 0 and 3: search starts at 3, then wraps to 0.
        pulseDone(4'b1001);
        applyStimulus(mkData(8'h55), 3);
        applyStimulus(mkData(8'h66), 0);

        // Free everything: pointer is now at 1.
        repeat (2) @(negedge clk);
        pulseDone(4'b1111);
        applyStimulus(mkData(8'h77), 1);
        repeat (2) @(negedge clk);

        // Engine 0 externally busy after reset: first task skips to engine 1.
        rstn    = 1'b0;
        pe_busy = 4'b0001;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        applyStimulus(mkData(8'h88), 1);
        repeat (2) @(negedge clk);
        pe_busy = '0;

        // Reset landing on the issue edge discards the task and its occupancy.
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        applyStimulus(mkData(8'h99), 0);
        rstn = 1'b0;
        @(negedge clk);
        checkOutput("midrst_occ", 160'(dut.occ), 160'(0));
        checkOutput("midrst_pe_data", 160'(pe_data), 160'(0));
        checkOutput("midrst_all_idle", 160'(all_idle), 160'(1));
        @(negedge clk);
        checkOutput("midrst_no_start", 160'(pe_start), 160'(0));
        rstn = 1'b1;

`ifdef DISPATCH_STATS_EN
        @(negedge clk);
        checkOutput("cnt_after_rst", 160'(dispatch_count), 160'(0));
        force dut.dispatch_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.dispatch_cnt;
        applyStimulus(mkData(8'hAA), 0);
        @(negedge clk);
        checkOutput("cnt_wrap", 160'(dispatch_count), 160'(0));
`endif

        repeat (4) @(negedge clk);
        checkOutput("sb_drained", 160'(sb.size()), 160'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
